// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer that makes ready_o a pure register output.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  input  logic              clr_cnt_i
);
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              in_xfer;
  logic              out_xfer;
  logic              stall;

  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = out_valid && ready_i;
  assign stall    = out_valid && !ready_i && !flush_i;
  assign valid_o  = out_valid;
  assign data_o   = out_data;
  // An empty stage always presents a bubble, whatever stale ctrl the register holds.
  assign ctrl_o   = out_valid ? out_ctrl : '0;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign ready_o = !skid_valid;

  always_ff @(posedge clk_i or negedge start_i)
    if (!start_i) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ctrl   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (flush_i) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (out_xfer || !out_valid) begin
      // The older skid beat must leave before anything new so order is preserved.
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_ctrl   <= skid_ctrl;
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
      end else begin
        out_valid <= in_xfer;
        if (in_xfer) begin
          out_data <= data_i;
          out_ctrl <= ctrl_i;
        end
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      skid_data  <= data_i;
      skid_ctrl  <= ctrl_i;
    end
`else
  assign ready_o = !out_valid || ready_i;

  always_ff @(posedge clk_i or negedge start_i)
    if (!start_i) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= data_i;
      out_ctrl  <= ctrl_i;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
`endif

  always_ff @(posedge clk_i or negedge start_i)
    if (!start_i)
      stall_cnt_o <= '0;
    else if (clr_cnt_i)
      stall_cnt_o <= '0;
    else if (stall && stall_cnt_o != {CNT_W{1'b1}})
      stall_cnt_o <= stall_cnt_o + 1'b1;
endmodule
